// File: rtl/cajero_multicuenta.sv
// cajero_multicuenta: ATM session controller.
// Flow per session: card accept, PIN entry with attempt counting and lockout, then one
// deposit or withdrawal on the session balance, then wait for card removal.
// Inactivity in an input-waiting state aborts the session with a TIMEOUT pulse.
// Build option: define WITHDRAW_LIMIT_EN to enable the per-session cumulative withdrawal
// cap (LIMITE_RETIRO); without it LIMITE_EXCEDIDO is tied low.

module cajero_multicuenta #(
  parameter int               PIN_DIGITS     = 4,
  parameter int               MAX_INTENTOS   = 3,
  parameter int               BAL_W          = 64,
  parameter int               MONTO_W        = 32,
  parameter int               TIMEOUT_CICLOS = 1000,
  parameter logic [BAL_W-1:0] LIMITE_RETIRO  = BAL_W'(50000)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TARJETA_RECIBIDA,
  input  logic [4*PIN_DIGITS-1:0] PIN_CORRECTO,
  input  logic [3:0]              DIGITO,
  input  logic                    DIGITO_STB,
  input  logic                    TIPO_TRANS,
  input  logic [MONTO_W-1:0]      MONTO,
  input  logic                    MONTO_STB,
  input  logic [BAL_W-1:0]        BALANCE_INICIAL,
  output logic [BAL_W-1:0]        BALANCE_ACTUALIZADO,
  output logic                    BALANCE_STB,
  output logic                    ENTREGAR_DINERO,
  output logic                    FONDOS_INSUFICIENTES,
  output logic                    PIN_INCORRECTO,
  output logic                    ADVERTENCIA,
  output logic                    BLOQUEO,
  output logic                    TIMEOUT,
  output logic                    LIMITE_EXCEDIDO
);

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_CHECK, S_TRANS, S_DEPOSIT, S_WITHDRAW, S_DONE, S_LOCKED
  } estado_t;

  localparam int DIG_W = $clog2(PIN_DIGITS);
  localparam int TMO_W = $clog2(TIMEOUT_CICLOS);

  localparam logic [DIG_W-1:0] DIG_ULTIMO = DIG_W'(PIN_DIGITS - 1);
  localparam logic [TMO_W-1:0] TMO_ULTIMO = TMO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [3:0]       INT_MAX    = 4'(MAX_INTENTOS);
  localparam logic [3:0]       INT_AVISO  = 4'(MAX_INTENTOS - 1);

  estado_t                 estado_q, estado_d;
  logic [4*PIN_DIGITS-1:0] pin_q, pin_d;
  logic [DIG_W-1:0]        dig_cnt_q, dig_cnt_d;
  logic [3:0]              intentos_q, intentos_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [BAL_W-1:0]        balance_q, balance_d;
  logic                    balance_stb_q, balance_stb_d;
  logic                    entregar_q, entregar_d;
  logic                    fondos_q, fondos_d;
  logic                    pin_inc_q, pin_inc_d;
  logic                    adv_q, adv_d;
  logic                    bloqueo_q, bloqueo_d;
  logic                    timeout_q, timeout_d;

`ifdef WITHDRAW_LIMIT_EN
  logic [BAL_W-1:0] acc_q, acc_d;
  logic             limite_q, limite_d;
  logic [BAL_W:0]   acc_suma;
  logic             excede_limite;
`endif

  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   suma;
  logic             sin_fondos;
  logic             en_espera;
  logic             en_sesion;
  logic             strobe_ok;
  logic             tmo_expira;
  logic [3:0]       intentos_nuevo;

  // Amount arithmetic and activity qualifiers shared by the next-state logic.
  assign monto_ext      = BAL_W'(MONTO);
  assign suma           = {1'b0, balance_q} + {1'b0, monto_ext};
  assign sin_fondos     = monto_ext > balance_q;
  assign en_espera      = estado_q inside {S_PIN, S_DEPOSIT, S_WITHDRAW};
  assign en_sesion      = estado_q inside {S_PIN, S_CHECK, S_TRANS, S_DEPOSIT, S_WITHDRAW};
  assign strobe_ok      = ((estado_q == S_PIN) && DIGITO_STB) ||
                          ((estado_q inside {S_DEPOSIT, S_WITHDRAW}) && MONTO_STB);
  // A strobe in the expiry cycle is accepted instead of timing out.
  assign tmo_expira     = en_espera && !strobe_ok && (tmo_q == TMO_ULTIMO);
  assign intentos_nuevo = intentos_q + 4'd1;

`ifdef WITHDRAW_LIMIT_EN
  assign acc_suma       = {1'b0, acc_q} + {1'b0, monto_ext};
  assign excede_limite  = acc_suma > {1'b0, LIMITE_RETIRO};
`endif

  // Next-state and next-output computation for the whole session controller.
  always_comb begin
    // NOTE: every _d starts from its held value (pulses from 0) so no path through the case
    // leaves a signal unassigned and infers a latch.
    estado_d      = estado_q;
    pin_d         = pin_q;
    dig_cnt_d     = dig_cnt_q;
    intentos_d    = intentos_q;
    balance_d     = balance_q;
    pin_inc_d     = pin_inc_q;
    adv_d         = adv_q;
    bloqueo_d     = bloqueo_q;
    balance_stb_d = 1'b0;
    entregar_d    = 1'b0;
    fondos_d      = 1'b0;
    timeout_d     = 1'b0;
    tmo_d         = (en_espera && !strobe_ok) ? tmo_q + TMO_W'(1) : '0;
`ifdef WITHDRAW_LIMIT_EN
    acc_d         = acc_q;
    limite_d      = 1'b0;
`endif

    if (en_sesion && !TARJETA_RECIBIDA) begin
      // Card pulled mid-session: drop everything, keep the balance as it was.
      estado_d  = S_IDLE;
      dig_cnt_d = '0;
      pin_inc_d = 1'b0;
      adv_d     = 1'b0;
    end else begin
      case (estado_q)
        S_IDLE: begin
          if (TARJETA_RECIBIDA) begin
            estado_d  = S_PIN;
            balance_d = BALANCE_INICIAL;
            dig_cnt_d = '0;
`ifdef WITHDRAW_LIMIT_EN
            acc_d     = '0;
`endif
          end
        end
        S_PIN: begin
          if (DIGITO_STB) begin
            pin_d = {pin_q[4*PIN_DIGITS-5:0], DIGITO};
            if (dig_cnt_q == DIG_ULTIMO) begin
              estado_d  = S_CHECK;
              dig_cnt_d = '0;
            end else begin
              dig_cnt_d = dig_cnt_q + DIG_W'(1);
            end
          end else if (tmo_expira) begin
            timeout_d = 1'b1;
            estado_d  = S_DONE;
          end
        end
        S_CHECK: begin
          if (pin_q == PIN_CORRECTO) begin
            intentos_d = '0;
            pin_inc_d  = 1'b0;
            adv_d      = 1'b0;
            estado_d   = S_TRANS;
          end else begin
            intentos_d = intentos_nuevo;
            pin_inc_d  = 1'b1;
            adv_d      = (intentos_nuevo == INT_AVISO);
            dig_cnt_d  = '0;
            if (intentos_nuevo == INT_MAX) begin
              bloqueo_d = 1'b1;
              estado_d  = S_LOCKED;
            end else begin
              estado_d  = S_PIN;
            end
          end
        end
        S_TRANS: begin
          estado_d = TIPO_TRANS ? S_WITHDRAW : S_DEPOSIT;
        end
        S_DEPOSIT: begin
          if (MONTO_STB) begin
            // Saturate at all-ones instead of wrapping.
            balance_d     = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
            balance_stb_d = 1'b1;
            estado_d      = S_DONE;
          end else if (tmo_expira) begin
            timeout_d = 1'b1;
            estado_d  = S_DONE;
          end
        end
        S_WITHDRAW: begin
          if (MONTO_STB) begin
            balance_stb_d = 1'b1;
            estado_d      = S_DONE;
            if (sin_fondos) begin
              fondos_d = 1'b1;
`ifdef WITHDRAW_LIMIT_EN
            end else if (excede_limite) begin
              limite_d = 1'b1;
`endif
            end else begin
              balance_d  = balance_q - monto_ext;
              entregar_d = 1'b1;
`ifdef WITHDRAW_LIMIT_EN
              acc_d      = acc_suma[BAL_W-1:0];
`endif
            end
          end else if (tmo_expira) begin
            timeout_d = 1'b1;
            estado_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (!TARJETA_RECIBIDA) begin
            estado_d  = S_IDLE;
            pin_inc_d = 1'b0;
            adv_d     = 1'b0;
          end
        end
        S_LOCKED: begin
          // Absorbing: only reset leaves this state.
        end
        default: estado_d = S_IDLE;
      endcase
    end

    // Any state change restarts the inactivity window.
    if (estado_d != estado_q) tmo_d = '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      estado_q      <= S_IDLE;
      pin_q         <= '0;
      dig_cnt_q     <= '0;
      intentos_q    <= '0;
      tmo_q         <= '0;
      balance_q     <= '0;
      balance_stb_q <= 1'b0;
      entregar_q    <= 1'b0;
      fondos_q      <= 1'b0;
      pin_inc_q     <= 1'b0;
      adv_q         <= 1'b0;
      bloqueo_q     <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef WITHDRAW_LIMIT_EN
      acc_q         <= '0;
      limite_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge _d values together.
      estado_q      <= estado_d;
      pin_q         <= pin_d;
      dig_cnt_q     <= dig_cnt_d;
      intentos_q    <= intentos_d;
      tmo_q         <= tmo_d;
      balance_q     <= balance_d;
      balance_stb_q <= balance_stb_d;
      entregar_q    <= entregar_d;
      fondos_q      <= fondos_d;
      pin_inc_q     <= pin_inc_d;
      adv_q         <= adv_d;
      bloqueo_q     <= bloqueo_d;
      timeout_q     <= timeout_d;
`ifdef WITHDRAW_LIMIT_EN
      acc_q         <= acc_d;
      limite_q      <= limite_d;
`endif
    end
  end

  assign BALANCE_ACTUALIZADO  = balance_q;
  assign BALANCE_STB          = balance_stb_q;
  assign ENTREGAR_DINERO      = entregar_q;
  assign FONDOS_INSUFICIENTES = fondos_q;
  assign PIN_INCORRECTO       = pin_inc_q;
  assign ADVERTENCIA          = adv_q;
  assign BLOQUEO              = bloqueo_q;
  assign TIMEOUT              = timeout_q;

`ifdef WITHDRAW_LIMIT_EN
  assign LIMITE_EXCEDIDO = limite_q;
`else
  logic unused_limite;
  assign unused_limite   = ^LIMITE_RETIRO;
  assign LIMITE_EXCEDIDO = 1'b0;
`endif

endmodule

// File: tb/tb_cajero_multicuenta.sv
// Testbench for cajero_multicuenta (default build, TIMEOUT_CICLOS = 8).
// Directed scenarios plus randomized sessions checked against a behavioural account model.

module tb_cajero_multicuenta;

  localparam int          MAX_I = 3;
  localparam logic [63:0] MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TARJETA_RECIBIDA;
  logic [15:0] PIN_CORRECTO;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic        TIPO_TRANS;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic [63:0] BALANCE_INICIAL;
  logic [63:0] BALANCE_ACTUALIZADO;
  logic        BALANCE_STB, ENTREGAR_DINERO, FONDOS_INSUFICIENTES;
  logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, TIMEOUT, LIMITE_EXCEDIDO;

  int tests = 0;
  int fails = 0;

  // Behavioural account model.
  logic [63:0] m_bal;
  int          m_int;
  bit          m_pin_inc, m_adv, m_lock;

  cajero_multicuenta #(.TIMEOUT_CICLOS(8)) dut (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
    .PIN_CORRECTO(PIN_CORRECTO), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
    .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO), .MONTO_STB(MONTO_STB),
    .BALANCE_INICIAL(BALANCE_INICIAL), .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO),
    .BALANCE_STB(BALANCE_STB), .ENTREGAR_DINERO(ENTREGAR_DINERO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .PIN_INCORRECTO(PIN_INCORRECTO),
    .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO), .TIMEOUT(TIMEOUT),
    .LIMITE_EXCEDIDO(LIMITE_EXCEDIDO)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bal"}, BALANCE_ACTUALIZADO, 64'd0);
    check({tag, "_stb"}, BALANCE_STB, 64'd0);
    check({tag, "_ent"}, ENTREGAR_DINERO, 64'd0);
    check({tag, "_fon"}, FONDOS_INSUFICIENTES, 64'd0);
    check({tag, "_pin"}, PIN_INCORRECTO, 64'd0);
    check({tag, "_adv"}, ADVERTENCIA, 64'd0);
    check({tag, "_blq"}, BLOQUEO, 64'd0);
    check({tag, "_tmo"}, TIMEOUT, 64'd0);
    check({tag, "_lim"}, LIMITE_EXCEDIDO, 64'd0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_pin_inc"}, PIN_INCORRECTO, 64'(m_pin_inc));
    check({tag, "_adv"}, ADVERTENCIA, 64'(m_adv));
    check({tag, "_blq"}, BLOQUEO, 64'(m_lock));
  endtask

  // Failed-attempt rule: correct PIN clears the count, otherwise count up and lock at the max.
  task automatic model_attempt(input bit ok);
    if (ok) begin
      m_int = 0; m_pin_inc = 0; m_adv = 0;
    end else begin
      m_int++;
      m_pin_inc = 1;
      m_adv = (m_int == MAX_I - 1);
      if (m_int >= MAX_I) m_lock = 1;
    end
  endtask

  task automatic model_reset();
    m_bal = '0; m_int = 0; m_pin_inc = 0; m_adv = 0; m_lock = 0;
  endtask

  task automatic send_digits(input logic [15:0] p, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      DIGITO = p[15-4*i -: 4];
      DIGITO_STB = 1'b1;
      tick();
      DIGITO_STB = 1'b0;
    end
  endtask

  task automatic insert(input logic [63:0] bal, input string tag);
    TARJETA_RECIBIDA = 1'b1;
    BALANCE_INICIAL = bal;
    tick();
    m_bal = bal;
    check({tag, "_load"}, BALANCE_ACTUALIZADO, m_bal);
  endtask

  // Full PIN entry; flags are visible two cycles after the last digit strobe.
  task automatic enter_pin(input logic [15:0] p, input string tag);
    send_digits(p, 0, 4);
    tick();
    model_attempt(p == PIN_CORRECTO);
    check_flags(tag);
  endtask

  // From TRANS: one transaction, pulse checks, then card removal.
  task automatic transact(input bit tipo, input logic [31:0] monto, input string tag);
    logic [64:0] s;
    logic [63:0] exp_bal;
    bit          exp_ent, exp_fon;
    TIPO_TRANS = tipo;
    tick();
    exp_bal = m_bal; exp_ent = 0; exp_fon = 0;
    if (!tipo) begin
      s = 65'(m_bal) + 65'(monto);
      exp_bal = (s > 65'(MAX64)) ? MAX64 : s[63:0];
    end else if (64'(monto) > m_bal) begin
      exp_fon = 1;
    end else begin
      exp_bal = m_bal - 64'(monto);
      exp_ent = 1;
    end
    MONTO = monto;
    MONTO_STB = 1'b1;
    tick();
    MONTO_STB = 1'b0;
    check({tag, "_stb"}, BALANCE_STB, 64'd1);
    check({tag, "_ent"}, ENTREGAR_DINERO, 64'(exp_ent));
    check({tag, "_fon"}, FONDOS_INSUFICIENTES, 64'(exp_fon));
    check({tag, "_lim"}, LIMITE_EXCEDIDO, 64'd0);
    check({tag, "_bal"}, BALANCE_ACTUALIZADO, exp_bal);
    m_bal = exp_bal;
    tick();
    check({tag, "_stb_end"}, BALANCE_STB, 64'd0);
    check({tag, "_ent_end"}, ENTREGAR_DINERO, 64'd0);
    TARJETA_RECIBIDA = 1'b0;
    tick();
    m_pin_inc = 0; m_adv = 0;
    check_flags({tag, "_exit"});
  endtask

  initial begin : stim
    logic [63:0] bal;
    logic [31:0] monto;
    logic [15:0] wrong;
    bit          tipo;

    RESET = 1'b0;
    TARJETA_RECIBIDA = 1'b0;
    PIN_CORRECTO = 16'h1234;
    DIGITO = '0; DIGITO_STB = 1'b0;
    TIPO_TRANS = 1'b0;
    MONTO = '0; MONTO_STB = 1'b0;
    BALANCE_INICIAL = '0;
    model_reset();
    tick(); tick();
    check_zero("reset");
    RESET = 1'b1;
    tick();

    // Deposit 250 onto 500.
    insert(64'd500, "t1");
    enter_pin(16'h1234, "t1_pin");
    transact(1'b0, 32'd250, "t1_dep");

    // Failed-attempt count survives a card removal.
    insert(64'd40, "pers");
    enter_pin(16'h9999, "pers_w1");
    TARJETA_RECIBIDA = 1'b0;
    tick();
    insert(64'd40, "pers2");
    enter_pin(16'h1235, "pers_w2");
    enter_pin(16'h1234, "pers_ok");
    transact(1'b1, 32'd0, "pers_wd0");

    // Insufficient funds then exact withdrawal.
    insert(64'd100, "t3a");
    enter_pin(16'h1234, "t3a_pin");
    transact(1'b1, 32'd101, "t3a_wd");
    insert(m_bal, "t3b");
    enter_pin(16'h1234, "t3b_pin");
    transact(1'b1, 32'd100, "t3b_wd");

    // Saturating deposit.
    insert(MAX64 - 64'd9, "t4");
    enter_pin(16'h1234, "t4_pin");
    transact(1'b0, 32'd20, "t4_dep");

    // Inactivity timeout in PIN entry.
    insert(64'd777, "t5a");
    send_digits(16'h1234, 0, 2);
    repeat (7) tick();
    check("t5a_tmo_early", TIMEOUT, 64'd0);
    tick();
    check("t5a_tmo", TIMEOUT, 64'd1);
    check("t5a_stb", BALANCE_STB, 64'd0);
    tick();
    check("t5a_tmo_end", TIMEOUT, 64'd0);
    TARJETA_RECIBIDA = 1'b0;
    tick();
    check("t5a_bal", BALANCE_ACTUALIZADO, 64'd777);

    // Strobe in the expiry cycle wins; then timeout in DEPOSIT.
    insert(64'd777, "t5b");
    send_digits(16'h1234, 0, 2);
    repeat (7) tick();
    send_digits(16'h1234, 2, 1);
    check("t5b_no_tmo", TIMEOUT, 64'd0);
    send_digits(16'h1234, 3, 1);
    tick();
    model_attempt(1'b1);
    check_flags("t5b_pin");
    TIPO_TRANS = 1'b0;
    tick();
    repeat (7) tick();
    check("t5c_tmo_early", TIMEOUT, 64'd0);
    tick();
    check("t5c_tmo", TIMEOUT, 64'd1);
    check("t5c_stb", BALANCE_STB, 64'd0);
    check("t5c_bal", BALANCE_ACTUALIZADO, 64'd777);
    TARJETA_RECIBIDA = 1'b0;
    tick();

    // Card pulled in the same cycle as the deposit strobe: no update.
    insert(64'd5000, "drop");
    enter_pin(16'h1234, "drop_pin");
    TIPO_TRANS = 1'b0;
    tick();
    MONTO = 32'd10; MONTO_STB = 1'b1; TARJETA_RECIBIDA = 1'b0;
    tick();
    MONTO_STB = 1'b0;
    check("drop_stb", BALANCE_STB, 64'd0);
    check("drop_bal", BALANCE_ACTUALIZADO, 64'd5000);

    // Strobes in IDLE are ignored.
    DIGITO_STB = 1'b1; MONTO_STB = 1'b1;
    tick();
    DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
    tick();
    check("idle_stb", BALANCE_STB, 64'd0);
    check("idle_bal", BALANCE_ACTUALIZADO, 64'd5000);

    // Randomized sessions.
    for (int j = 0; j < 24; j++) begin
      PIN_CORRECTO = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      wrong = PIN_CORRECTO ^ (16'h1 << (4 * $urandom_range(0, 3)));
      tipo  = 1'($urandom_range(0, 1));
      case (j % 3)
        0: begin bal = MAX64 - 64'($urandom_range(0, 1000)); monto = $urandom; end
        1: begin bal = {$urandom, $urandom}; monto = $urandom; end
        default: begin
          bal = 64'($urandom_range(0, 1000));
          monto = (j % 5 == 0) ? bal[31:0] : 32'($urandom_range(0, 2000));
        end
      endcase
      insert(bal, "rnd");
      if ($urandom_range(0, 2) == 0) enter_pin(wrong, "rnd_wrong");
      enter_pin(PIN_CORRECTO, "rnd_pin");
      transact(tipo, monto, "rnd_tr");
    end

    // Async reset mid-withdrawal.
    PIN_CORRECTO = 16'h1234;
    insert(64'd1000, "arst");
    enter_pin(16'h1234, "arst_pin");
    TIPO_TRANS = 1'b1;
    tick();
    #3;
    RESET = 1'b0;
    #1;
    check_zero("arst");
    TARJETA_RECIBIDA = 1'b0;
    model_reset();
    tick();
    RESET = 1'b1;
    tick();

    // Lockout after three wrong PINs; correct PIN then ignored.
    insert(64'd300, "t2");
    enter_pin(16'h1111, "t2_w1");
    enter_pin(16'h2222, "t2_w2");
    enter_pin(16'h3333, "t2_w3");
    send_digits(16'h1234, 0, 4);
    tick(); tick();
    check_flags("t2_locked_pin");
    TIPO_TRANS = 1'b0;
    MONTO = 32'd5; MONTO_STB = 1'b1;
    tick();
    MONTO_STB = 1'b0;
    tick();
    check("t2_locked_stb", BALANCE_STB, 64'd0);
    check("t2_locked_bal", BALANCE_ACTUALIZADO, 64'd300);
    TARJETA_RECIBIDA = 1'b0;
    tick();
    check_flags("t2_locked_card");
    #3;
    RESET = 1'b0;
    #1;
    check_zero("t2_rst");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
